// File: rtl/mux_scan_reg_if.sv
// Bus between the scan multiplexer and its surroundings: parallel channel inputs,
// selection controls and the valid/ready output sample.
interface mux_scan_reg_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [N_CH*W-1:0] d;
  logic [SEL_W-1:0]  sel;
  logic              mode;
  logic              en;
  logic [W-1:0]      f;
  logic [SEL_W-1:0]  f_ch;
  logic              f_valid;
  logic              f_ready;

  modport master (
    output d, sel, mode, en, f_ready,
    input  f, f_ch, f_valid
  );

  modport slave (
    input  d, sel, mode, en, f_ready,
    output f, f_ch, f_valid
  );
endinterface

// File: rtl/mux_scan_reg.sv
// N_CH:1 multiplexer with a registered output slot, valid/ready backpressure and
// an auto-scan mode that dwells DWELL accepted samples on each channel.
module mux_scan_reg #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_reg_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_CH);
  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      f_q, f_d;
  logic [SEL_W-1:0]  f_ch_q, f_ch_d;
  logic [SEL_W-1:0]  scan_ch_q, scan_ch_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;

  logic              valid_c;
  logic              free_c;
  logic              capture_c;
  logic [SEL_W-1:0]  ch_c;
  logic [W-1:0]      data_c;

  assign valid_c   = (state_q != EMPTY);
  assign free_c    = !valid_c || bus.f_ready;
  assign capture_c = bus.en && free_c;
  assign ch_c      = bus.mode ? scan_ch_q : bus.sel;

  // Channel mux; indices with no channel behind them yield zero.
  always_comb begin
    data_c = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (ch_c == SEL_W'(k)) data_c = bus.d[k*W +: W];
    end
  end

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    f_ch_d    = f_ch_q;
    scan_ch_d = scan_ch_q;
    dwell_d   = dwell_q;

    unique case (state_q)
      EMPTY: begin
        if (capture_c) state_d = FULL;
      end
      FULL, STALL: begin
        if (!bus.f_ready)  state_d = STALL;
        else if (bus.en)   state_d = FULL;
        else               state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (capture_c) begin
      f_d    = data_c;
      f_ch_d = ch_c;
    end

    // Scan position only advances on accepted samples, so stalls never skip a channel.
    if (!bus.mode) begin
      scan_ch_d = '0;
      dwell_d   = '0;
    end else if (capture_c) begin
      if (dwell_q == DW_W'(DWELL - 1)) begin
        dwell_d   = '0;
        scan_ch_d = (scan_ch_q == SEL_W'(N_CH - 1)) ? '0 : scan_ch_q + SEL_W'(1);
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      f_q       <= '0;
      f_ch_q    <= '0;
      scan_ch_q <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      f_q       <= f_d;
      f_ch_q    <= f_ch_d;
      scan_ch_q <= scan_ch_d;
      dwell_q   <= dwell_d;
    end
  end

  assign bus.f       = f_q;
  assign bus.f_ch    = f_ch_q;
  assign bus.f_valid = valid_c;
endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed and randomized checks of two mux_scan_reg instances (4 channels / DWELL=2,
// and 3 channels / DWELL=1) against a sample-count based reference model.
module tb_mux_scan_reg;
  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  // Reference state per instance: 0 = four-channel, 1 = three-channel.
  int mv[2];
  int mf[2];
  int mch[2];
  int scan_n[2];

  mux_scan_reg_if #(.N_CH(4), .W(8)) b4 ();
  mux_scan_reg_if #(.N_CH(3), .W(8)) b3 ();

  mux_scan_reg #(.N_CH(4), .W(8), .DWELL(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux_scan_reg #(.N_CH(3), .W(8), .DWELL(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mf[i] = 0; mch[i] = 0; scan_n[i] = 0;
    end
  endfunction

  // Scan channel is the number of accepted scan samples divided by the dwell, modulo N_CH.
  function automatic void model_step(input int id, input int nch, input int dwell,
                                     input int unsigned dpk, input int sel,
                                     input bit mode, input bit en, input bit fr);
    bit free;
    int ch;
    free = (mv[id] == 0) || fr;
    if (en && free) begin
      ch      = mode ? (scan_n[id] / dwell) % nch : sel;
      mf[id]  = (ch < nch) ? int'((dpk >> (ch * 8)) & 32'hFF) : 0;
      mch[id] = ch;
      mv[id]  = 1;
      if (mode) scan_n[id]++;
    end else if (!en && fr) begin
      mv[id] = 0;
    end
    if (!mode) scan_n[id] = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("f4",       32'(b4.f),       mf[0]);
    chk("f_ch4",    32'(b4.f_ch),    mch[0]);
    chk("f_valid4", 32'(b4.f_valid), mv[0]);
    chk("f3",       32'(b3.f),       mf[1]);
    chk("f_ch3",    32'(b3.f_ch),    mch[1]);
    chk("f_valid3", 32'(b3.f_valid), mv[1]);
  endtask

  task automatic tick();
    model_step(0, 4, 2, 32'(b4.d), int'(b4.sel), b4.mode, b4.en, b4.f_ready);
    model_step(1, 3, 1, 32'(b3.d), int'(b3.sel), b3.mode, b3.en, b3.f_ready);
    @(posedge clk);
    #1;
    check_all();
  endtask

  int seq4[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int seq5a[4] = '{0, 0, 1, 1};
  int seq5b[3] = '{2, 2, 3};
  int seq6[4] = '{0, 1, 2, 0};
  logic [31:0] d3_pat;

  initial begin
    // Reset
    rst_n = 1'b0;
    b4.d = '0; b4.sel = '0; b4.mode = 1'b0; b4.en = 1'b0; b4.f_ready = 1'b1;
    b3.d = '0; b3.sel = '0; b3.mode = 1'b0; b3.en = 1'b0; b3.f_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    tick();
    chk("reset_f",     32'(b4.f),       0);
    chk("reset_valid", 32'(b4.f_valid), 0);

    // Direct select
    b4.d = 32'h44332211; b4.sel = 2'd2; b4.en = 1'b1;
    tick();
    chk("direct_f",  32'(b4.f),       32'h33);
    chk("direct_ch", 32'(b4.f_ch),    2);
    chk("direct_v",  32'(b4.f_valid), 1);
    b4.sel = 2'd0;
    tick();
    chk("direct_sel0", 32'(b4.f), 32'h11);

    // Stall holds the sample while inputs change
    b4.sel = 2'd2;
    tick();
    b4.f_ready = 1'b0;
    b4.d = 32'h44AA2211;
    b4.sel = 2'd1;
    repeat (3) begin
      tick();
      chk("stall_hold_f", 32'(b4.f), 32'h33);
    end
    b4.sel = 2'd2;
    b4.f_ready = 1'b1;
    tick();
    chk("stall_release_f", 32'(b4.f), 32'hAA);

    // Scan, DWELL=2
    b4.d = 32'h44332211;
    b4.mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("scan_ch", 32'(b4.f_ch), seq4[i]);
      chk("scan_f",  32'(b4.f),    32'h11 * (seq4[i] + 1));
    end

    // Scan with a stall on the second channel-1 sample, then reset mid-stall
    b4.mode = 1'b0; b4.sel = 2'd0;
    tick();
    b4.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("scan5_ch", 32'(b4.f_ch), seq5a[i]);
    end
    b4.f_ready = 1'b0;
    repeat (4) begin
      tick();
      chk("scan5_hold", 32'(b4.f_ch), 1);
    end
    b4.f_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("scan5_resume", 32'(b4.f_ch), seq5b[i]);
    end
    b4.f_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", 32'(b4.f_valid), 0);
    chk("async_rst_f",     32'(b4.f),       0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b4.f_ready = 1'b1;
    tick();
    chk("rst_scan_restart", 32'(b4.f_ch), 0);
    tick();
    tick();
    chk("rst_scan_next", 32'(b4.f_ch), 1);

    // Three channels: out-of-range select, then scan never reaches index 3
    b4.en = 1'b0;
    b3.d = 24'hCCBBAA; b3.sel = 2'd3; b3.en = 1'b1; b3.f_ready = 1'b1;
    tick();
    chk("oor_f",  32'(b3.f),       0);
    chk("oor_ch", 32'(b3.f_ch),    3);
    chk("oor_v",  32'(b3.f_valid), 1);
    b3.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("scan3_ch", 32'(b3.f_ch), seq6[i]);
      chk("scan3_f",  32'(b3.f),    32'hAA + 32'h11 * seq6[i]);
    end

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      b4.d = $urandom;
      d3_pat = $urandom;
      b3.d = d3_pat[23:0];
      b4.sel = 2'($urandom);
      b3.sel = 2'($urandom);
      if ($urandom_range(7) == 0) b4.mode = ~b4.mode;
      if ($urandom_range(7) == 0) b3.mode = ~b3.mode;
      b4.en = ($urandom_range(3) != 0);
      b3.en = ($urandom_range(3) != 0);
      b4.f_ready = ($urandom_range(2) != 0);
      b3.f_ready = ($urandom_range(2) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
